// File: rtl/frontend_cmd_arbiter_if.sv
// Signal bundle around frontend_cmd_arbiter: two requester ports, backend command port
// and backend read-return port. slave = arbiter side, master = environment side.
interface frontend_cmd_arbiter_if #(
   parameter int unsigned CMD_W  = 28,
   parameter int unsigned DATA_W = 64
);
   logic [CMD_W-1:0]  req0_command;
   logic [DATA_W-1:0] req0_write_data;
   logic              req0_valid;
   logic              req0_ready;
   logic [DATA_W-1:0] req0_read_data;
   logic              req0_read_data_valid;

   logic [CMD_W-1:0]  req1_command;
   logic [DATA_W-1:0] req1_write_data;
   logic              req1_valid;
   logic              req1_ready;
   logic [DATA_W-1:0] req1_read_data;
   logic              req1_read_data_valid;

   logic [CMD_W-1:0]  command;
   logic [DATA_W-1:0] write_data;
   logic              valid;
   logic              ba_cmd_pm;
   logic [DATA_W-1:0] read_data;
   logic              read_data_valid;
   logic              tag_err;

   modport slave (
      input  req0_command, req0_write_data, req0_valid,
      output req0_ready, req0_read_data, req0_read_data_valid,
      input  req1_command, req1_write_data, req1_valid,
      output req1_ready, req1_read_data, req1_read_data_valid,
      output command, write_data, valid,
      input  ba_cmd_pm, read_data, read_data_valid,
      output tag_err
   );

   modport master (
      output req0_command, req0_write_data, req0_valid,
      input  req0_ready, req0_read_data, req0_read_data_valid,
      output req1_command, req1_write_data, req1_valid,
      input  req1_ready, req1_read_data, req1_read_data_valid,
      input  command, write_data, valid,
      output ba_cmd_pm, read_data, read_data_valid,
      input  tag_err
   );
endinterface

// File: rtl/frontend_cmd_arbiter.sv
// Round-robin arbiter with bounded row-hit streak for the shared frontend command port,
// plus an in-order tag FIFO steering backend read data to the issuing requester.
// Command word: op_type in the top 2 bits (1 = read), row_addr at [COL_W +: ROW_W].
module frontend_cmd_arbiter #(
   parameter int unsigned CMD_W      = 28,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned ROW_W      = 14,
   parameter int unsigned COL_W      = 10,
   parameter int unsigned TAG_DEPTH  = 8,
   parameter int unsigned MAX_STREAK = 4
) (
   input logic                   clk,
   input logic                   power_on_rst,
   frontend_cmd_arbiter_if.slave bus
);
   localparam int unsigned OP_W  = 2;
   localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned STK_W = $clog2(MAX_STREAK + 1);
   localparam logic [OP_W-1:0]  OP_READ  = OP_W'(1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);
   localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_STREAK);

   logic [CMD_W-1:0]     cmd_r;
   logic [DATA_W-1:0]    wdata_r;
   logic                 valid_r;
   logic                 tag_err_r;
   logic [TAG_DEPTH-1:0] tag_mem;
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     tag_cnt;
   logic [STK_W-1:0]     streak;
   logic                 last_grant;
   logic [ROW_W-1:0]     last_row;

   logic                 load_c, fifo_full_c, fifo_empty_c;
   logic                 rd0_c, rd1_c, elig0_c, elig1_c, row_hit_c;
   logic                 gnt_vld_c, gnt_id_c, push_c, pop_c, head_c;
   logic [ROW_W-1:0]     last_req_row_c;
   logic [CMD_W-1:0]     gnt_cmd_c;
   logic [DATA_W-1:0]    gnt_wdata_c;

   assign load_c       = !valid_r || bus.ba_cmd_pm;
   assign fifo_full_c  = (tag_cnt == FULL_CNT);
   assign fifo_empty_c = (tag_cnt == '0);
   assign rd0_c        = (bus.req0_command[CMD_W-1 -: OP_W] == OP_READ);
   assign rd1_c        = (bus.req1_command[CMD_W-1 -: OP_W] == OP_READ);
   // A pop in the same cycle does not free a slot for a new read.
   assign elig0_c      = bus.req0_valid && (!rd0_c || !fifo_full_c);
   assign elig1_c      = bus.req1_valid && (!rd1_c || !fifo_full_c);

   assign last_req_row_c = last_grant ? bus.req1_command[COL_W +: ROW_W]
                                      : bus.req0_command[COL_W +: ROW_W];
   assign row_hit_c      = (last_req_row_c == last_row) && (streak < STK_MAX);

   // Grant selection; only evaluated when the output register can load.
   always_comb begin
      gnt_vld_c = 1'b0;
      gnt_id_c  = 1'b0;
      if (load_c) begin
         if (elig0_c && elig1_c) begin
            gnt_vld_c = 1'b1;
            gnt_id_c  = row_hit_c ? last_grant : !last_grant;
         end else if (elig0_c) begin
            gnt_vld_c = 1'b1;
            gnt_id_c  = 1'b0;
         end else if (elig1_c) begin
            gnt_vld_c = 1'b1;
            gnt_id_c  = 1'b1;
         end
      end
   end

   assign gnt_cmd_c   = gnt_id_c ? bus.req1_command    : bus.req0_command;
   assign gnt_wdata_c = gnt_id_c ? bus.req1_write_data : bus.req0_write_data;
   assign push_c      = gnt_vld_c && (gnt_id_c ? rd1_c : rd0_c);
   assign pop_c       = bus.read_data_valid && !fifo_empty_c;
   assign head_c      = tag_mem[rd_ptr];

   assign bus.req0_ready           = gnt_vld_c && !gnt_id_c;
   assign bus.req1_ready           = gnt_vld_c && gnt_id_c;
   assign bus.req0_read_data       = bus.read_data;
   assign bus.req1_read_data       = bus.read_data;
   assign bus.req0_read_data_valid = pop_c && !head_c;
   assign bus.req1_read_data_valid = pop_c && head_c;
   assign bus.command              = cmd_r;
   assign bus.write_data           = wdata_r;
   assign bus.valid                = valid_r;
   assign bus.tag_err              = tag_err_r;

   // Backend output register; payload holds when nothing is granted.
   always_ff @(posedge clk) begin
      if (power_on_rst) begin
         cmd_r   <= '0;
         wdata_r <= '0;
         valid_r <= 1'b0;
      end else if (load_c) begin
         valid_r <= gnt_vld_c;
         if (gnt_vld_c) begin
            cmd_r   <= gnt_cmd_c;
            wdata_r <= gnt_wdata_c;
         end
      end
   end

   // Round-robin and row-hit streak state.
   always_ff @(posedge clk) begin
      if (power_on_rst) begin
         streak     <= '0;
         last_grant <= 1'b1;
         last_row   <= '0;
      end else if (gnt_vld_c) begin
         last_row <= gnt_cmd_c[COL_W +: ROW_W];
         if (gnt_id_c == last_grant) begin
            if (streak < STK_MAX) streak <= STK_W'(streak + 1'b1);
         end else begin
            streak     <= STK_W'(1);
            last_grant <= gnt_id_c;
         end
      end
   end

   // In-order tag FIFO of read issuers and the sticky underflow flag.
   always_ff @(posedge clk) begin
      if (power_on_rst) begin
         tag_mem   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         tag_cnt   <= '0;
         tag_err_r <= 1'b0;
      end else begin
         if (push_c) begin
            tag_mem[wr_ptr] <= gnt_id_c;
            wr_ptr          <= PTR_W'(wr_ptr + 1'b1);
         end
         if (pop_c) rd_ptr <= PTR_W'(rd_ptr + 1'b1);
         if (push_c && !pop_c)      tag_cnt <= CNT_W'(tag_cnt + 1'b1);
         else if (!push_c && pop_c) tag_cnt <= CNT_W'(tag_cnt - 1'b1);
         if (bus.read_data_valid && fifo_empty_c) tag_err_r <= 1'b1;
      end
   end
endmodule
